householder_matrix_gen: RTL and testbench

Sequential, parametrised generator of the N×N Householder reflection H = I − 2·w·wᵀ from a captured vector w, for the matrix-inverse datapath. It supersedes the fixed 2×2 combinational-multiplier form. It streams H element by element over a valid/ready handshake, with configurable dimension and fixed-point formats. It adds rounding, saturation with a sticky flag, and a symmetric (upper-triangle-only) emission mode. It sits between the w normalisation stage and the matrix-multiply stage.

---
 rtl/householder_matrix_gen.sv | 185 ++++++++++++++++++
 tb/tb_householder_matrix_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/householder_matrix_gen.sv
// householder_matrix_gen
//
// Streams the N x N Householder reflection H = I - 2*w*w^T, one element per handshake,
// from a vector w captured at start. Each element takes a multiply cycle and a
// format cycle (round half-up, saturate), then waits in EMIT until accepted.
//
// Ports:
//   I_sys_clk   - clock, rising edge
//   I_sys_rstn  - synchronous active-low reset
//   I_start     - start request, honoured only in IDLE
//   I_sym       - 1: emit only col >= row, captured with I_start
//   I_w_flat    - packed w vector, element i at [i*IN_W +: IN_W]
//   I_h_ready   - downstream ready
//   O_h_valid   - element output valid
//   O_h_data    - H element, signed, OUT_FRAC fraction bits
//   O_h_row     - row index of O_h_data
//   O_h_col     - column index of O_h_data
//   O_busy      - run in progress (start accepted through DONE)
//   O_done      - one-cycle pulse after the last element is accepted
//   O_sat       - sticky saturation flag for the current/last run
module householder_matrix_gen #(
  parameter int unsigned N        = 4,
  parameter int unsigned IN_W     = 32,
  parameter int unsigned IN_FRAC  = 8,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 8,
  parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic              I_start,
  input  logic              I_sym,
  input  logic [N*IN_W-1:0] I_w_flat,
  input  logic              I_h_ready,
  output logic              O_h_valid,
  output logic [OUT_W-1:0]  O_h_data,
  output logic [IDX_W-1:0]  O_h_row,
  output logic [IDX_W-1:0]  O_h_col,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_sat
);

  localparam int unsigned PW = 2 * IN_W;
  localparam int unsigned TW = 2 * IN_W + 2;
  localparam int unsigned SH = 2 * IN_FRAC - OUT_FRAC;

  localparam logic signed [TW-1:0] TOne   = TW'(1) << (2 * IN_FRAC);
  localparam logic signed [TW-1:0] RndAdd = TW'(1) << (SH - 1);
  localparam logic signed [TW-1:0] SatMax = (TW'(1) << (OUT_W - 1)) - TW'(1);
  localparam logic signed [TW-1:0] SatMin = -(TW'(1) << (OUT_W - 1));

  typedef enum logic [2:0] {StIdle, StMul, StForm, StEmit, StDone} state_e;

  state_e                   state_q, state_d;
  logic signed [IN_W-1:0]   w_q [N];
  logic signed [IN_W-1:0]   w_d [N];
  logic                     sym_q, sym_d;
  logic [IDX_W-1:0]         row_q, row_d, col_q, col_d;
  logic signed [PW-1:0]     p_q, p_d;
  logic [OUT_W-1:0]         data_q, data_d;
  logic [IDX_W-1:0]         hrow_q, hrow_d, hcol_q, hcol_d;
  logic                     sat_q, sat_d;

  logic signed [PW-1:0]     mul_a, mul_b;
  logic signed [TW-1:0]     t_val, t_rnd, t_sh;
  logic [OUT_W-1:0]         res;
  logic                     sat_hit;
  logic                     row_end, last_elem;

  // Format datapath: T = delta*2^(2*IN_FRAC) - 2P, round half-up, saturate.
  always_comb begin
    mul_a   = PW'(w_q[row_q]);
    mul_b   = PW'(w_q[col_q]);
    t_val   = ((row_q == col_q) ? TOne : '0) - {p_q[PW-1], p_q, 1'b0};
    t_rnd   = t_val + RndAdd;
    t_sh    = t_rnd >>> SH;
    sat_hit = 1'b0;
    if (t_sh > SatMax) begin
      res     = {1'b0, {(OUT_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (t_sh < SatMin) begin
      res     = {1'b1, {(OUT_W-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      res = t_sh[OUT_W-1:0];
    end
  end

  assign row_end   = (col_q == IDX_W'(N - 1));
  assign last_elem = row_end && (row_q == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    sym_d   = sym_q;
    row_d   = row_q;
    col_d   = col_q;
    p_d     = p_q;
    data_d  = data_q;
    hrow_d  = hrow_q;
    hcol_d  = hcol_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (I_start) begin
          for (int i = 0; i < N; i++) begin
            w_d[i] = I_w_flat[i*IN_W +: IN_W];
          end
          sym_d   = I_sym;
          row_d   = '0;
          col_d   = '0;
          sat_d   = 1'b0;
          state_d = StMul;
        end
      end
      StMul: begin
        p_d     = mul_a * mul_b;
        state_d = StForm;
      end
      StForm: begin
        data_d  = res;
        hrow_d  = row_q;
        hcol_d  = col_q;
        if (sat_hit) sat_d = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        if (I_h_ready) begin
          if (last_elem) begin
            state_d = StDone;
          end else begin
            if (row_end) begin
              row_d = row_q + 1'b1;
              // Symmetric mode restarts each row on the diagonal.
              col_d = sym_q ? row_q + 1'b1 : '0;
            end else begin
              col_d = col_q + 1'b1;
            end
            state_d = StMul;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rstn) begin
      state_q <= StIdle;
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
      end
      sym_q  <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
      p_q    <= '0;
      data_q <= '0;
      hrow_q <= '0;
      hcol_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      sym_q   <= sym_d;
      row_q   <= row_d;
      col_q   <= col_d;
      p_q     <= p_d;
      data_q  <= data_d;
      hrow_q  <= hrow_d;
      hcol_q  <= hcol_d;
      sat_q   <= sat_d;
    end
  end

  assign O_h_valid = (state_q == StEmit);
  assign O_h_data  = data_q;
  assign O_h_row   = hrow_q;
  assign O_h_col   = hcol_q;
  assign O_busy    = (state_q != StIdle);
  assign O_done    = (state_q == StDone);
  assign O_sat     = sat_q;

endmodule

// File: tb/tb_householder_matrix_gen.sv
module tb_householder_matrix_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        sym = 1'b0;
  logic        sel = 1'b0;   // 0: N=2 instance, 1: N=3 instance
  logic        bp = 1'b0;    // backpressure mode
  logic [95:0] w = '0;
  logic        ready = 1'b0;
  logic        mon_en = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int done_seen = 0;
  int hold_cnt = 0;

  logic        a_start, a_valid, a_busy, a_done, a_sat;
  logic [15:0] a_data;
  logic [0:0]  a_row, a_col;
  logic        b_start, b_valid, b_busy, b_done, b_sat;
  logic [15:0] b_data;
  logic [1:0]  b_row, b_col;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  householder_matrix_gen #(.N(2)) dut_a (
    .I_sys_clk (clk),
    .I_sys_rstn(rstn),
    .I_start   (a_start),
    .I_sym     (sym),
    .I_w_flat  (w[63:0]),
    .I_h_ready (ready),
    .O_h_valid (a_valid),
    .O_h_data  (a_data),
    .O_h_row   (a_row),
    .O_h_col   (a_col),
    .O_busy    (a_busy),
    .O_done    (a_done),
    .O_sat     (a_sat)
  );

  householder_matrix_gen #(.N(3)) dut_b (
    .I_sys_clk (clk),
    .I_sys_rstn(rstn),
    .I_start   (b_start),
    .I_sym     (sym),
    .I_w_flat  (w),
    .I_h_ready (ready),
    .O_h_valid (b_valid),
    .O_h_data  (b_data),
    .O_h_row   (b_row),
    .O_h_col   (b_col),
    .O_busy    (b_busy),
    .O_done    (b_done),
    .O_sat     (b_sat)
  );

  logic        m_valid, m_busy, m_done, m_sat;
  logic [15:0] m_data;
  logic [1:0]  m_row, m_col;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_sat   = sel ? b_sat   : a_sat;
  assign m_data  = sel ? b_data  : a_data;
  assign m_row   = sel ? b_row   : {1'b0, a_row};
  assign m_col   = sel ? b_col   : {1'b0, a_col};

  typedef struct packed {
    logic [1:0]  r;
    logic [1:0]  c;
    logic [15:0] d;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit           sel;
    bit           sym;
    bit           bp;
    logic [31:0]  w0, w1, w2;
    bit           sat;
    logic [143:0] dd;   // expected data in emission order, first element in the MSBs
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready generator: always high, or held low for 5 cycles on every element.
  always @(posedge clk) begin
    #1;
    if (!bp) begin
      ready = 1'b1;
    end else if (m_valid) begin
      if (hold_cnt < 5) begin
        ready = 1'b0;
        hold_cnt++;
      end else begin
        ready = 1'b1;
        hold_cnt = 0;
      end
    end else begin
      ready = 1'b0;
      hold_cnt = 0;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  logic        prev_v = 1'b0;
  logic        prev_hs = 1'b0;
  logic [15:0] prev_d = '0;
  logic [1:0]  prev_r = '0, prev_c = '0;
  always @(negedge clk) begin
    if (!rstn || !mon_en) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_v && !prev_hs) begin
        chk("valid_held", {31'b0, m_valid}, 32'd1);
        if (m_valid) begin
          chk("hold_data", {16'b0, m_data}, {16'b0, prev_d});
          chk("hold_rc", {28'b0, m_row, m_col}, {28'b0, prev_r, prev_c});
        end
      end
      if (m_valid && !prev_v) chk("valid_gap", cyc - ref_cyc, 32'd2);
      if (m_valid && ready) begin
        if (q.size() == 0) begin
          chk("extra_elem", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", {16'b0, m_data}, {16'b0, e.d});
          chk("row", {30'b0, m_row}, {30'b0, e.r});
          chk("col", {30'b0, m_col}, {30'b0, e.c});
        end
        ref_cyc = cyc + 1;
      end
      if (m_done) done_seen++;
      prev_v  = m_valid;
      prev_hs = m_valid && ready;
      prev_d  = m_data;
      prev_r  = m_row;
      prev_c  = m_col;
    end
  end

  task automatic run_vec(input vec_t v);
    int n, k;
    bit got;
    sel = v.sel;
    sym = v.sym;
    bp  = v.bp;
    w   = {v.w2, v.w1, v.w0};
    n   = v.sel ? 3 : 2;
    k   = 0;
    for (int r = 0; r < n; r++) begin
      for (int c = (v.sym ? r : 0); c < n; c++) begin
        exp_t e;
        e.r = 2'(r);
        e.c = 2'(c);
        e.d = v.dd[143 - 16*k -: 16];
        q.push_back(e);
        k++;
      end
    end
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    ref_cyc = cyc;
    start = 1'b0;
    chk("busy_after_start", {31'b0, m_busy}, 32'd1);
    chk("sat_cleared", {31'b0, m_sat}, 32'd0);
    chk("no_early_valid", {31'b0, m_valid}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_done) begin
        got = 1'b1;
        break;
      end
      // Start pulses with junk inputs while busy must be ignored.
      if (v.bp && (i % 7 == 3)) begin
        start = 1'b1;
        w = ~w;
        sym = ~sym;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen_in_time", {31'b0, got}, 32'd1);
    if (got) begin
      chk("busy_with_done", {31'b0, m_busy}, 32'd1);
      @(posedge clk); #1;
      chk("done_pulse_end", {30'b0, m_done, m_busy}, 32'd0);
      chk("sat_flag", {31'b0, m_sat}, {31'b0, v.sat});
      @(posedge clk); #1;
      chk("sat_sticky", {31'b0, m_sat}, {31'b0, v.sat});
      chk("done_count", done_seen, 32'd1);
      chk("all_elems", q.size(), 32'd0);
    end
    q.delete();
  endtask

  initial begin
    vt[0] = '{sel:0, sym:0, bp:0, w0:32'd128, w1:32'd128, w2:32'd0, sat:0,
              dd:{16'h0080, 16'hFF80, 16'hFF80, 16'h0080, 80'h0}};
    vt[1] = '{sel:0, sym:0, bp:0, w0:32'd256, w1:32'd0, w2:32'd0, sat:0,
              dd:{16'hFF00, 16'h0000, 16'h0000, 16'h0100, 80'h0}};
    vt[2] = '{sel:0, sym:0, bp:0, w0:32'd4096, w1:32'd0, w2:32'd0, sat:1,
              dd:{16'h8000, 16'h0000, 16'h0000, 16'h0100, 80'h0}};
    vt[3] = '{sel:0, sym:0, bp:0, w0:32'd1, w1:32'd1, w2:32'd0, sat:0,
              dd:{16'h0100, 16'h0000, 16'h0000, 16'h0100, 80'h0}};
    vt[4] = '{sel:1, sym:1, bp:0, w0:32'd128, w1:32'd128, w2:32'd0, sat:0,
              dd:{16'h0080, 16'hFF80, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 48'h0}};
    vt[5] = '{sel:1, sym:0, bp:1, w0:32'd128, w1:32'd128, w2:32'd0, sat:0,
              dd:{16'h0080, 16'hFF80, 16'h0000, 16'hFF80, 16'h0080, 16'h0000,
                  16'h0000, 16'h0000, 16'h0100}};
    vt[6] = '{sel:0, sym:0, bp:0, w0:32'hFFFF_FF00, w1:32'd128, w2:32'd0, sat:0,
              dd:{16'hFF00, 16'h0100, 16'h0100, 16'h0080, 80'h0}};
    vt[7] = '{sel:0, sym:0, bp:1, w0:32'd4096, w1:32'hFFFF_F000, w2:32'd0, sat:1,
              dd:{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 80'h0}};

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {10'b0, a_valid, a_data, a_row, a_col, a_busy, a_done, a_sat}, 32'd0);
    chk("rst_b", {8'b0, b_valid, b_data, b_row, b_col, b_busy, b_done, b_sat}, 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Symmetric run with saturation on the last diagonal element, under backpressure.
    begin
      vec_t v;
      v = '{sel:1, sym:1, bp:1, w0:32'd0, w1:32'd0, w2:32'd16384, sat:1,
            dd:{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 48'h0}};
      run_vec(v);
    end

    // Reset while an element is held in EMIT, then a clean run from (0,0).
    mon_en = 1'b0;
    sel = 1'b0;
    sym = 1'b0;
    bp = 1'b1;
    w = {32'd0, 32'd128, 32'd128};
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (m_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rst_test_valid", {31'b0, seen}, 32'd1);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_run", {10'b0, a_valid, a_data, a_row, a_col, a_busy, a_done, a_sat}, 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;
    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
